// File: rtl/wm_sram_1rw1r.sv
// Single-clock SRAM with one read/write port and one read-only port, optional
// power-on clear sequence, registered outputs and access-error reporting.
module wm_sram_1rw1r #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_WORDS      = 200,
    parameter int ADDR_WIDTH     = 8,
    parameter int WMASK_WIDTH    = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_valid,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic                   ready,
    output logic                   collision,
    output logic                   addr_err
);

    // state   | meaning
    // ST_INIT | clearing word r_init_cnt, accesses ignored
    // ST_RUN  | normal operation, accesses accepted once r_ready is set

    localparam int                    LP_LANE = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LP_NUM  = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t LP_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic [ADDR_WIDTH-1:0]   w_init_cnt_nxt;
    logic                    w_clr_we;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];

    logic w_rd0;
    logic w_wr0;
    logic w_rd1;
    logic w_in0;
    logic w_in1;
    logic w_col;
    logic w_err;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_state    <= LP_RST_STATE;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_ready    <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_clr_we       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we       = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LP_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign ready = r_ready;
    assign w_rd0 = r_ready & ~csb0 & web0;
    assign w_wr0 = r_ready & ~csb0 & ~web0;
    assign w_rd1 = r_ready & ~csb1;
    assign w_in0 = ({1'b0, addr0} < LP_NUM);
    assign w_in1 = ({1'b0, addr1} < LP_NUM);
    assign w_col = w_wr0 & w_rd1 & (addr0 == addr1);
    // Both ports out of range on one edge still yields a single pulse.
    assign w_err = (r_ready & ~csb0 & ~w_in0) | (w_rd1 & ~w_in1);

    // Array has no reset so contents can survive reset when clearing is disabled.
    always_ff @(posedge clk0) begin
        if (w_clr_we) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr0 && w_in0) begin
            for (int k = 0; k < WMASK_WIDTH; k++) begin
                if (wmask0[k]) begin
                    r_mem[addr0][k*LP_LANE +: LP_LANE] <= din0[k*LP_LANE +: LP_LANE];
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout0       <= '0;
            dout1       <= '0;
            dout0_valid <= 1'b0;
            dout1_valid <= 1'b0;
            collision   <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            dout0_valid <= w_rd0;
            dout1_valid <= w_rd1;
            collision   <= w_col;
            addr_err    <= w_err;
            if (w_rd0) begin
                dout0 <= w_in0 ? r_mem[addr0] : '0;
            end
            if (w_rd1) begin
                dout1 <= w_in1 ? r_mem[addr1] : '0;
            end
        end
    end

endmodule

// File: tb/tb_wm_sram_1rw1r.sv
// Self-checking bench for wm_sram_1rw1r: directed scenarios plus randomized
// dual-port traffic compared against an array-based reference memory.
module tb_wm_sram_1rw1r;

    localparam int NW = 200;

    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        csb0, web0, csb1;
    logic [1:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [15:0] din0, dout0, dout1;
    logic        dout0_valid, dout1_valid, ready, collision, addr_err;

    logic        n_rst_n;
    logic        n_csb0, n_web0, n_csb1;
    logic [1:0]  n_wmask0;
    logic [7:0]  n_addr0, n_addr1;
    logic [15:0] n_din0, n_dout0, n_dout1;
    logic        n_dout0_valid, n_dout1_valid, n_ready, n_collision, n_addr_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [NW];
    logic [15:0] exp_d0, exp_d1, m, v;
    logic        exp_v0, exp_v1, exp_col, exp_err;
    logic        r_c0, r_w0, r_c1;
    logic [1:0]  r_wm;
    logic [7:0]  r_a0, r_a1;
    logic [15:0] r_d;
    int          n;
    logic        saw_valid;

    always #5 clk0 = ~clk0;

    wm_sram_1rw1r dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dout0_valid(dout0_valid),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .dout1_valid(dout1_valid),
        .ready(ready), .collision(collision), .addr_err(addr_err)
    );

    wm_sram_1rw1r #(.CLEAR_ON_RESET(0)) dut_nc (
        .clk0(clk0), .rst0_n(n_rst_n),
        .csb0(n_csb0), .web0(n_web0), .wmask0(n_wmask0), .addr0(n_addr0), .din0(n_din0),
        .dout0(n_dout0), .dout0_valid(n_dout0_valid),
        .csb1(n_csb1), .addr1(n_addr1), .dout1(n_dout1), .dout1_valid(n_dout1_valid),
        .ready(n_ready), .collision(n_collision), .addr_err(n_addr_err)
    );

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic set_p0(input logic c, input logic w, input logic [1:0] wm,
                          input logic [7:0] a, input logic [15:0] d);
        csb0 = c; web0 = w; wmask0 = wm; addr0 = a; din0 = d;
    endtask

    task automatic set_p1(input logic c, input logic [7:0] a);
        csb1 = c; addr1 = a;
    endtask

    task automatic idle();
        set_p0(1'b1, 1'b1, 2'b00, 8'd0, 16'h0000);
        set_p1(1'b1, 8'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic model_write(input logic [1:0] wm, input logic [7:0] a, input logic [15:0] d);
        logic [15:0] mk;
        mk = {{8{wm[1]}}, {8{wm[0]}}};
        if (int'(a) < NW) ref_mem[a] = (ref_mem[a] & ~mk) | (d & mk);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    task automatic test_reset();
        rst0_n = 1'b0; n_rst_n = 1'b0;
        set_p0(1'b0, 1'b1, 2'b00, 8'd3, 16'h0000);
        set_p1(1'b0, 8'd3);
        n_csb0 = 1'b1; n_web0 = 1'b1; n_wmask0 = 2'b00; n_addr0 = 8'd0; n_din0 = 16'h0;
        n_csb1 = 1'b1; n_addr1 = 8'd0;
        step(); step(); step();
        checks++;
        if ({dout0, dout1, dout0_valid, dout1_valid, ready, collision, addr_err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got d0=%h d1=%h v0=%b v1=%b rdy=%b col=%b err=%b expected all zero",
                     dout0, dout1, dout0_valid, dout1_valid, ready, collision, addr_err);
        end
        checks++;
        if ({n_dout0, n_dout0_valid, n_ready} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs_nc: got d0=%h v0=%b rdy=%b expected zero", n_dout0, n_dout0_valid, n_ready);
        end
    endtask

    task automatic test_init();
        int cnt;
        idle();
        rst0_n = 1'b1;
        wait_ready(cnt);
        checks++;
        if (cnt != NW) begin
            errors++;
            $display("FAIL init_ready_edges: got %0d expected %0d", cnt, NW);
        end
        model_clear();
        for (int a = 0; a < NW; a++) begin
            set_p0(1'b0, 1'b1, 2'b00, 8'(a), 16'h0);
            set_p1(1'b0, 8'(NW - 1 - a));
            step();
            checks++;
            if (dout0 !== 16'h0000 || dout0_valid !== 1'b1 || dout1 !== 16'h0000 || dout1_valid !== 1'b1) begin
                errors++;
                $display("FAIL init_cleared a=%0d: got d0=%h v0=%b d1=%h v1=%b expected 0000/1", a,
                         dout0, dout0_valid, dout1, dout1_valid);
            end
        end
        idle();
        exp_d0 = 16'h0000; exp_d1 = 16'h0000;
    endtask

    task automatic test_mask();
        set_p0(1'b0, 1'b0, 2'b11, 8'd5, 16'hABCD); step(); model_write(2'b11, 8'd5, 16'hABCD);
        set_p0(1'b0, 1'b0, 2'b01, 8'd5, 16'h1234); step(); model_write(2'b01, 8'd5, 16'h1234);
        set_p0(1'b0, 1'b0, 2'b00, 8'd5, 16'h9999); step();
        set_p0(1'b0, 1'b1, 2'b00, 8'd5, 16'h0000); step();
        checks++;
        if (dout0 !== 16'hAB34 || dout0_valid !== 1'b1) begin
            errors++;
            $display("FAIL mask_read: got %h v=%b expected ab34 v=1", dout0, dout0_valid);
        end
        idle(); step();
        checks++;
        if (dout0 !== 16'hAB34 || dout0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask_hold: got %h v=%b expected ab34 v=0", dout0, dout0_valid);
        end
        exp_d0 = 16'hAB34;
    endtask

    task automatic test_collision();
        set_p0(1'b0, 1'b0, 2'b11, 8'd7, 16'h5555);
        set_p1(1'b0, 8'd7);
        step(); model_write(2'b11, 8'd7, 16'h5555);
        checks++;
        if (dout1 !== 16'h0000 || dout1_valid !== 1'b1 || collision !== 1'b1) begin
            errors++;
            $display("FAIL collision_rbw: got d1=%h v1=%b col=%b expected 0000/1/1", dout1, dout1_valid, collision);
        end
        idle(); set_p1(1'b0, 8'd7); step();
        checks++;
        if (dout1 !== 16'h5555 || collision !== 1'b0) begin
            errors++;
            $display("FAIL collision_after: got d1=%h col=%b expected 5555/0", dout1, collision);
        end
        set_p0(1'b0, 1'b1, 2'b00, 8'd7, 16'h0); set_p1(1'b0, 8'd7); step();
        checks++;
        if (dout0 !== 16'h5555 || dout1 !== 16'h5555 || collision !== 1'b0 || dout0_valid !== 1'b1) begin
            errors++;
            $display("FAIL dual_read: got d0=%h d1=%h col=%b expected 5555/5555/0", dout0, dout1, collision);
        end
        idle();
        exp_d0 = 16'h5555; exp_d1 = 16'h5555;
    endtask

    task automatic test_addr_err();
        set_p0(1'b0, 1'b0, 2'b11, 8'd200, 16'hFFFF); step();
        checks++;
        if (addr_err !== 1'b1 || collision !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_write: got err=%b col=%b expected 1/0", addr_err, collision);
        end
        set_p0(1'b0, 1'b1, 2'b00, 8'd72, 16'h0); set_p1(1'b0, 8'd250); step();
        checks++;
        if (dout0 !== ref_mem[72] || dout1 !== 16'h0000 || dout1_valid !== 1'b1 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_read: got d0=%h d1=%h v1=%b err=%b expected %h/0000/1/1",
                     dout0, dout1, dout1_valid, addr_err, ref_mem[72]);
        end
        set_p0(1'b0, 1'b1, 2'b00, 8'd210, 16'h0); set_p1(1'b0, 8'd220); step();
        checks++;
        if (addr_err !== 1'b1 || dout0 !== 16'h0000 || dout0_valid !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_both: got err=%b d0=%h v0=%b expected 1/0000/1", addr_err, dout0, dout0_valid);
        end
        idle(); step();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_single_pulse: got %b expected 0", addr_err);
        end
        exp_d0 = 16'h0000; exp_d1 = 16'h0000;
    endtask

    task automatic test_random_back_to_back();
        for (int i = 0; i < 500; i++) begin
            r_c0 = ($urandom_range(0, 4) == 0);
            r_w0 = $urandom_range(0, 1);
            r_c1 = ($urandom_range(0, 4) == 0);
            if (i == 0) begin r_c0 = 1'b0; r_w0 = 1'b1; r_c1 = 1'b0; end
            r_wm = 2'($urandom_range(0, 3));
            r_a0 = 8'($urandom_range(0, 215));
            r_a1 = ($urandom_range(0, 3) == 0) ? r_a0 : 8'($urandom_range(0, 215));
            r_d  = 16'($urandom);
            exp_v0 = !r_c0 && r_w0;
            exp_v1 = !r_c1;
            if (exp_v0) exp_d0 = (int'(r_a0) < NW) ? ref_mem[r_a0] : 16'h0000;
            if (exp_v1) exp_d1 = (int'(r_a1) < NW) ? ref_mem[r_a1] : 16'h0000;
            exp_col = !r_c0 && !r_w0 && !r_c1 && (r_a0 == r_a1);
            exp_err = (!r_c0 && int'(r_a0) >= NW) || (!r_c1 && int'(r_a1) >= NW);
            if (!r_c0 && !r_w0) model_write(r_wm, r_a0, r_d);
            set_p0(r_c0, r_w0, r_wm, r_a0, r_d);
            set_p1(r_c1, r_a1);
            step();
            checks++;
            if (dout0 !== exp_d0 || dout0_valid !== exp_v0 || dout1 !== exp_d1 || dout1_valid !== exp_v1
                || collision !== exp_col || addr_err !== exp_err) begin
                errors++;
                $display("FAIL random[%0d]: got d0=%h v0=%b d1=%h v1=%b col=%b err=%b expected %h %b %h %b %b %b",
                         i, dout0, dout0_valid, dout1, dout1_valid, collision, addr_err,
                         exp_d0, exp_v0, exp_d1, exp_v1, exp_col, exp_err);
            end
        end
        idle();
        for (int a = 0; a < NW; a += 7) begin
            set_p1(1'b0, 8'(a)); step();
            checks++;
            if (dout1 !== ref_mem[a]) begin
                errors++;
                $display("FAIL random_final a=%0d: got %h expected %h", a, dout1, ref_mem[a]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        set_p0(1'b0, 1'b1, 2'b00, 8'd5, 16'h0); set_p1(1'b0, 8'd7); step();
        v = ref_mem[5];
        #2 rst0_n = 1'b0;
        #1;
        checks++;
        if ({dout0, dout1, dout0_valid, dout1_valid, ready, collision, addr_err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got d0=%h d1=%h v0=%b v1=%b rdy=%b expected zero (d0 was %h)",
                     dout0, dout1, dout0_valid, dout1_valid, ready, v);
        end
        step();
        rst0_n = 1'b1;
        saw_valid = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 400) begin
            step();
            cnt++;
            if (dout0_valid || dout1_valid || collision || addr_err) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0 || cnt != NW) begin
            errors++;
            $display("FAIL reset_mid_run_release: got pulse=%b edges=%0d expected 0/%0d", saw_valid, cnt, NW);
        end
        model_clear();
        step();
        checks++;
        if (dout0 !== 16'h0000 || dout0_valid !== 1'b1 || dout1 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_run_cleared: got d0=%h v0=%b d1=%h expected 0000/1/0000", dout0, dout0_valid, dout1);
        end
        idle();
    endtask

    task automatic test_reset_mid_init();
        int cnt;
        set_p0(1'b0, 1'b0, 2'b11, 8'd150, 16'h7777); step(); model_write(2'b11, 8'd150, 16'h7777);
        idle();
        rst0_n = 1'b0; step(); rst0_n = 1'b1;
        for (int i = 0; i < 100; i++) step();
        rst0_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || dout0_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_init: got rdy=%b v0=%b expected 0/0", ready, dout0_valid);
        end
        step();
        rst0_n = 1'b1;
        wait_ready(cnt);
        checks++;
        if (cnt != NW) begin
            errors++;
            $display("FAIL reset_mid_init_edges: got %0d expected %0d", cnt, NW);
        end
        model_clear();
        set_p1(1'b0, 8'd150); step();
        checks++;
        if (dout1 !== 16'h0000 || dout1_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_init_cleared: got %h v=%b expected 0000/1", dout1, dout1_valid);
        end
        idle();
    endtask

    task automatic test_no_clear();
        n_rst_n = 1'b1;
        step();
        checks++;
        if (n_ready !== 1'b1) begin
            errors++;
            $display("FAIL nc_ready_first: got %b expected 1", n_ready);
        end
        n_csb0 = 1'b0; n_web0 = 1'b0; n_wmask0 = 2'b11; n_addr0 = 8'd3; n_din0 = 16'h00FF;
        step();
        n_csb0 = 1'b1; n_web0 = 1'b1;
        n_rst_n = 1'b0;
        #1;
        checks++;
        if (n_ready !== 1'b0) begin
            errors++;
            $display("FAIL nc_reset_ready: got %b expected 0", n_ready);
        end
        step();
        n_rst_n = 1'b1;
        n_csb0 = 1'b0; n_web0 = 1'b1; n_addr0 = 8'd3;
        step();
        checks++;
        if (n_ready !== 1'b1 || n_dout0_valid !== 1'b0) begin
            errors++;
            $display("FAIL nc_ready_after_release: got rdy=%b v0=%b expected 1/0", n_ready, n_dout0_valid);
        end
        step();
        checks++;
        if (n_dout0 !== 16'h00FF || n_dout0_valid !== 1'b1) begin
            errors++;
            $display("FAIL nc_retained: got %h v=%b expected 00ff/1", n_dout0, n_dout0_valid);
        end
        n_csb0 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_init();
        test_mask();
        test_collision();
        test_addr_err();
        test_random_back_to_back();
        test_reset_mid_run();
        test_reset_mid_init();
        test_no_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wm_sram_1rw1r.md
WM_SRAM_1RW1R -- requirements
Module: wm_sram_1rw1r

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 Parameter NUM_WORDS, default 200: number of addressable words.
REQ-003 Parameter ADDR_WIDTH, default 8: address width; SHALL satisfy 2^ADDR_WIDTH >= NUM_WORDS.
REQ-004 Parameter WMASK_WIDTH, default 2: write-mask lanes; DATA_WIDTH SHALL be divisible by it; lane k covers bits [k*L+L-1 : k*L], L = DATA_WIDTH/WMASK_WIDTH.
REQ-005 Parameter CLEAR_ON_RESET, default 1: 1 = zero all words after reset; 0 = contents retained.
REQ-006 clk0  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst0_n  in  1  asynchronous, active-low reset.
REQ-008 csb0  in  1  port 0 (RW) active-low chip select.
REQ-009 web0  in  1  port 0 active-low write enable.
REQ-010 wmask0  in  WMASK_WIDTH  port 0 write lane enables, active-high.
REQ-011 addr0  in  ADDR_WIDTH  port 0 address.
REQ-012 din0  in  DATA_WIDTH  port 0 write data.
REQ-013 dout0  out  DATA_WIDTH  port 0 read data, registered.
REQ-014 dout0_valid  out  1  one-cycle pulse qualifying dout0.
REQ-015 csb1  in  1  port 1 (R) active-low chip select.
REQ-016 addr1  in  ADDR_WIDTH  port 1 address.
REQ-017 dout1  out  DATA_WIDTH  port 1 read data, registered.
REQ-018 dout1_valid  out  1  one-cycle pulse qualifying dout1.
REQ-019 ready  out  1  high when accesses are accepted.
REQ-020 collision  out  1  one-cycle pulse: port 0 write and port 1 read hit the same address.
REQ-021 addr_err  out  1  one-cycle pulse: an accepted access used address >= NUM_WORDS.

Function
REQ-022 States SHALL be INIT and RUN; reset enters INIT if CLEAR_ON_RESET=1, else RUN.
REQ-023 INIT: an internal counter SHALL write zero to word 0..NUM_WORDS-1, one word per cycle, starting on the first rising edge after rst0_n deasserts.
REQ-024 INIT->RUN on the edge that clears word NUM_WORDS-1; ready SHALL be 1 from that edge onward (NUM_WORDS edges after release).
REQ-025 While ready=0, csb0/csb1 SHALL be ignored: no write, no valid, no collision, no addr_err.
REQ-026 Port 0 write (ready, csb0=0, web0=0): on that edge, each lane with wmask0[k]=1 SHALL take din0; other lanes unchanged; wmask0=0 changes nothing.
REQ-027 Port 0 read (ready, csb0=0, web0=1): on that edge dout0 SHALL load mem[addr0] and dout0_valid SHALL be 1 for exactly that following cycle (latency 1).
REQ-028 Port 1 read (ready, csb1=0): same as REQ-027 with addr1, dout1, dout1_valid.
REQ-029 dout0/dout1 SHALL hold their last value when no read is accepted; valid SHALL be 0.
REQ-030 Same-edge port 0 write and port 1 read to the same address: dout1 SHALL return pre-write data (read-before-write) and collision SHALL pulse for one cycle; the write SHALL complete.
REQ-031 Port 0 read and port 1 read to the same address SHALL both succeed with no collision.
REQ-032 Address >= NUM_WORDS: write SHALL be dropped, read SHALL return 0 with valid=1; addr_err SHALL pulse once even if both ports are out of range.
REQ-033 Back-to-back accesses on every edge SHALL be supported with no bubbles.

Reset
REQ-034 rst0_n low SHALL immediately force dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision=0, addr_err=0, ready=0, init counter=0.
REQ-035 ready SHALL return to 1 on the first edge after release when CLEAR_ON_RESET=0.
REQ-036 Reset mid-INIT SHALL restart the clear from word 0; reset mid-RUN SHALL abandon the in-flight access (no valid pulse on release).
REQ-037 With CLEAR_ON_RESET=0 memory contents SHALL survive reset.

Verification
REQ-038 Release reset (defaults) -> ready rises exactly 200 edges later; read addr 0..199 -> all dout=0x0000.
REQ-039 Write addr 5 din=0xABCD wmask=2'b11, then din=0x1234 wmask=2'b01 -> port 0 read addr 5 returns 0xAB34 one cycle later with dout0_valid=1.
REQ-040 Same edge: port 0 writes 0x5555 to addr 7 (old 0x0000), port 1 reads addr 7 -> dout1=0x0000, collision pulse; next port 1 read returns 0x5555.
REQ-041 Port 0 write addr 200 din=0xFFFF -> addr_err pulse, no array change; port 1 read addr 250 -> dout1=0x0000, valid=1, addr_err pulse.
REQ-042 Assert rst0_n low at counter=100 during INIT -> outputs zero immediately; after release ready rises 200 edges later.
REQ-043 CLEAR_ON_RESET=0: write 0x00FF to addr 3, reset, read addr 3 -> 0x00FF; ready high one edge after release.
